// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB pipeline register, load extraction and register-file write-back.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module writeback_stage (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wb_sel,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_pc_plus4,
  input  logic [31:0] mem_imm,
  input  logic [31:0] mem_load_word,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic        load_misaligned,
  output logic        retire
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;
  localparam logic [1:0] SEL_IMM  = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_sel;
  logic [2:0]  wb_funct3;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_pc_plus4;
  logic [31:0] wb_imm;

  logic [1:0]  offset;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        misaligned;
  logic        commit;
  logic [31:0] sel_data;

  // Flush only drops valid; payload fields are don't-care once invalid.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= 5'd0;
      wb_sel        <= 2'b00;
      wb_funct3     <= 3'b000;
      wb_alu_result <= 32'd0;
      wb_pc_plus4   <= 32'd0;
      wb_imm        <= 32'd0;
    end else if (flush) begin
      wb_valid <= 1'b0;
    end else if (!stall) begin
      wb_valid      <= mem_valid;
      wb_reg_write  <= mem_reg_write;
      wb_rd         <= mem_rd;
      wb_sel        <= mem_wb_sel;
      wb_funct3     <= mem_funct3;
      wb_alu_result <= mem_alu_result;
      wb_pc_plus4   <= mem_pc_plus4;
      wb_imm        <= mem_imm;
    end
  end

  assign offset = wb_alu_result[1:0];

  always_comb begin
    ld_byte = mem_load_word[7:0];
    case (offset)
      2'd0: ld_byte = mem_load_word[7:0];
      2'd1: ld_byte = mem_load_word[15:8];
      2'd2: ld_byte = mem_load_word[23:16];
      2'd3: ld_byte = mem_load_word[31:24];
      default: ld_byte = mem_load_word[7:0];
    endcase
    ld_half = offset[1] ? mem_load_word[31:16] : mem_load_word[15:0];
  end

  always_comb begin
    ld_data = mem_load_word;
    case (wb_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'd0, ld_byte};
      F3_LHU:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_load_word;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if (wb_sel == SEL_LOAD) begin
      case (wb_funct3)
        F3_LW:          misaligned = (offset != 2'd0);
        F3_LH, F3_LHU:  misaligned = offset[0];
        default:        misaligned = 1'b0;
      endcase
    end
  end

  always_comb begin
    sel_data = wb_alu_result;
    case (wb_sel)
      SEL_ALU:  sel_data = wb_alu_result;
      SEL_LOAD: sel_data = ld_data;
      SEL_LINK: sel_data = wb_pc_plus4;
      SEL_IMM:  sel_data = wb_imm;
      default:  sel_data = wb_alu_result;
    endcase
  end

  // A stalled instruction stays resident and commits once, when stall releases.
  assign commit          = wb_valid & ~stall;
  assign rf_we           = commit & wb_reg_write & (wb_rd != 5'd0) & ~misaligned;
  assign rf_waddr        = wb_rd;
  assign rf_wdata        = wb_valid ? sel_data : 32'd0;
  assign fwd_valid       = rf_we;
  assign retire          = commit & ~misaligned;
  assign load_misaligned = commit & misaligned;

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      instret <= 64'd0;
    end else if (retire) begin
      instret <= instret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage.
// Also checks instret when built with WB_INSTRET_EN.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_pc_plus4;
  logic [31:0] mem_imm;
  logic [31:0] mem_load_word;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic        load_misaligned;
  logic        retire;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int n_pass = 0;
  int n_checks = 0;
  int retire_cnt;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .stall           (stall),
    .flush           (flush),
    .mem_valid       (mem_valid),
    .mem_reg_write   (mem_reg_write),
    .mem_rd          (mem_rd),
    .mem_wb_sel      (mem_wb_sel),
    .mem_funct3      (mem_funct3),
    .mem_alu_result  (mem_alu_result),
    .mem_pc_plus4    (mem_pc_plus4),
    .mem_imm         (mem_imm),
    .mem_load_word   (mem_load_word),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .fwd_valid       (fwd_valid),
    .load_misaligned (load_misaligned),
    .retire          (retire)
`ifdef WB_INSTRET_EN
    ,
    .instret         (instret)
`endif
  );

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] word;
    logic        we;
    logic [31:0] wdata;
    logic        mis;
    logic        ret;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_we"}, rf_we, 0);
    check({tag, "_waddr"}, rf_waddr, 0);
    check({tag, "_wdata"}, rf_wdata, 0);
    check({tag, "_fwd"}, fwd_valid, 0);
    check({tag, "_retire"}, retire, 0);
    check({tag, "_mis"}, load_misaligned, 0);
  endtask

  task automatic drive(input logic [2:0] f3, input logic [1:0] sel, input logic rw,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] imm);
    mem_valid = 1'b1; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_pc_plus4 = pc4; mem_imm = imm;
  endtask

  task automatic scramble;
    mem_valid = 1'b0; mem_reg_write = 1'b1; mem_rd = 5'd30; mem_wb_sel = 2'b11;
    mem_funct3 = 3'b111; mem_alu_result = 32'hFFFF_FFFF; mem_pc_plus4 = 32'hAAAA_AAAA;
    mem_imm = 32'h5555_5555;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 2'b01, 1'b1, 5'd5,  32'h1003, 32'h0, 32'h0, 32'h80FF_1234, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1};
    vecs[1]  = '{3'b100, 2'b01, 1'b1, 5'd5,  32'h1003, 32'h0, 32'h0, 32'h80FF_1234, 1'b1, 32'h0000_0080, 1'b0, 1'b1};
    vecs[2]  = '{3'b001, 2'b01, 1'b1, 5'd6,  32'h2002, 32'h0, 32'h0, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1};
    vecs[3]  = '{3'b101, 2'b01, 1'b1, 5'd6,  32'h2002, 32'h0, 32'h0, 32'h8001_7FFF, 1'b1, 32'h0000_8001, 1'b0, 1'b1};
    vecs[4]  = '{3'b001, 2'b01, 1'b1, 5'd6,  32'h2000, 32'h0, 32'h0, 32'h8001_7FFF, 1'b1, 32'h0000_7FFF, 1'b0, 1'b1};
    vecs[5]  = '{3'b000, 2'b01, 1'b1, 5'd8,  32'h0001, 32'h0, 32'h0, 32'h80FF_1234, 1'b1, 32'h0000_0012, 1'b0, 1'b1};
    vecs[6]  = '{3'b010, 2'b01, 1'b1, 5'd9,  32'h0001, 32'h0, 32'h0, 32'h80FF_1234, 1'b0, 32'h80FF_1234, 1'b1, 1'b0};
    vecs[7]  = '{3'b010, 2'b01, 1'b1, 5'd9,  32'h0000, 32'h0, 32'h0, 32'h80FF_1234, 1'b1, 32'h80FF_1234, 1'b0, 1'b1};
    vecs[8]  = '{3'b001, 2'b01, 1'b1, 5'd9,  32'h0003, 32'h0, 32'h0, 32'h80FF_1234, 1'b0, 32'hFFFF_80FF, 1'b1, 1'b0};
    vecs[9]  = '{3'b101, 2'b01, 1'b1, 5'd9,  32'h0001, 32'h0, 32'h0, 32'h80FF_1234, 1'b0, 32'h0000_1234, 1'b1, 1'b0};
    vecs[10] = '{3'b100, 2'b01, 1'b1, 5'd11, 32'h0002, 32'h0, 32'h0, 32'h80FF_1234, 1'b1, 32'h0000_00FF, 1'b0, 1'b1};
    vecs[11] = '{3'b010, 2'b10, 1'b1, 5'd1,  32'h0001, 32'h104, 32'h0, 32'h0, 1'b1, 32'h0000_0104, 1'b0, 1'b1};
    vecs[12] = '{3'b010, 2'b10, 1'b1, 5'd0,  32'h0001, 32'h104, 32'h0, 32'h0, 1'b0, 32'h0000_0104, 1'b0, 1'b1};
    vecs[13] = '{3'b000, 2'b11, 1'b1, 5'd10, 32'h0000, 32'h0, 32'h1234_5000, 32'h0, 1'b1, 32'h1234_5000, 1'b0, 1'b1};
    vecs[14] = '{3'b010, 2'b00, 1'b1, 5'd31, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1};
    vecs[15] = '{3'b011, 2'b01, 1'b1, 5'd12, 32'h0001, 32'h0, 32'h0, 32'h80FF_1234, 1'b1, 32'h80FF_1234, 1'b0, 1'b1};
    vecs[16] = '{3'b000, 2'b00, 1'b0, 5'd4,  32'h0042, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0000_0042, 1'b0, 1'b1};

    n_rst = 1'b0; stall = 1'b0; flush = 1'b0; mem_load_word = 32'h80FF_1234;
    drive(3'b000, 2'b01, 1'b1, 5'd5, 32'h1003, 32'h4, 32'h8);
    tick;
    tick;
    all_zero("reset");
`ifdef WB_INSTRET_EN
    check("reset_instret", instret, 64'd0);
`endif
    scramble;
    n_rst = 1'b1;
    tick;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].f3, vecs[i].sel, vecs[i].rw, vecs[i].rd, vecs[i].alu, vecs[i].pc4, vecs[i].imm);
      tick;
      scramble;
      mem_load_word = vecs[i].word;
      #1;
      check($sformatf("v%0d_we", i), rf_we, vecs[i].we);
      check($sformatf("v%0d_waddr", i), rf_waddr, vecs[i].rd);
      check($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].wdata);
      check($sformatf("v%0d_fwd", i), fwd_valid, vecs[i].we);
      check($sformatf("v%0d_mis", i), load_misaligned, vecs[i].mis);
      check($sformatf("v%0d_retire", i), retire, vecs[i].ret);
    end
    tick;
    check("bubble_we", rf_we, 0);
    check("bubble_wdata", rf_wdata, 0);
    check("bubble_retire", retire, 0);

    // stall for three cycles, then release: exactly one commit
    drive(3'b000, 2'b00, 1'b1, 5'd7, 32'h1234, 32'h0, 32'h0);
    tick;
    stall = 1'b1;
    drive(3'b000, 2'b00, 1'b1, 5'd9, 32'hDEAD, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stall%0d_we", i), rf_we, 0);
      check($sformatf("stall%0d_retire", i), retire, 0);
      check($sformatf("stall%0d_waddr", i), rf_waddr, 7);
      tick;
    end
    stall = 1'b0;
    scramble;
    #1;
    check("unstall_we", rf_we, 1);
    check("unstall_waddr", rf_waddr, 7);
    check("unstall_wdata", rf_wdata, 32'h1234);
    check("unstall_retire", retire, 1);
    tick;
    check("unstall_once_we", rf_we, 0);
    check("unstall_once_retire", retire, 0);

    // flush and stall together kill the resident instruction
    drive(3'b000, 2'b00, 1'b1, 5'd3, 32'h55, 32'h0, 32'h0);
    tick;
    scramble;
    stall = 1'b1; flush = 1'b1;
    #1;
    check("fs_we", rf_we, 0);
    check("fs_retire", retire, 0);
    tick;
    stall = 1'b0; flush = 1'b0;
    #1;
    check("fs_after_we", rf_we, 0);
    check("fs_after_retire", retire, 0);
    check("fs_after_wdata", rf_wdata, 0);

    // back-to-back commits
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, 2'b00, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h0, 32'h0);
      tick;
      check($sformatf("b2b%0d_we", i), rf_we, 1);
      check($sformatf("b2b%0d_waddr", i), rf_waddr, i + 1);
      check($sformatf("b2b%0d_wdata", i), rf_wdata, 32'h100 + 32'(i));
    end
    scramble;
    tick;

    // asynchronous reset while stalled
    drive(3'b000, 2'b00, 1'b1, 5'd6, 32'h77, 32'h0, 32'h0);
    tick;
    scramble;
    stall = 1'b1;
    #1;
    check("rst_stall_we", rf_we, 0);
    #2;
    n_rst = 1'b0;
    #1;
    all_zero("async_rst");
    tick;
    n_rst = 1'b1; stall = 1'b0;
    #1;
    check("post_rst_we", rf_we, 0);
    check("post_rst_retire", retire, 0);

    // 10 good, 1 misaligned, 2 flushed-at-capture
    retire_cnt = 0;
    mem_load_word = 32'h0;
    for (int i = 0; i < 13; i++) begin
      if (i == 4) drive(3'b010, 2'b01, 1'b1, 5'd2, 32'h2, 32'h0, 32'h0);
      else        drive(3'b000, 2'b00, 1'b1, 5'd2, 32'(i), 32'h0, 32'h0);
      flush = (i == 7 || i == 11);
      tick;
      flush = 1'b0;
      #1;
      if (retire) retire_cnt++;
    end
    scramble;
    tick;
    check("retire_count", retire_cnt, 10);
`ifdef WB_INSTRET_EN
    check("instret", instret, 64'd10);
    tick;
    check("instret_hold", instret, 64'd10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the five-stage RISC-V integer pipeline; sits directly downstream of the memory stage register. Captures MEM-stage control and ALU results into a MEM/WB pipeline register and extracts and sign/zero-extends load data from the registered memory word. It selects the write-back value and drives the register-file write port and the forwarding bus. Supports stall, flush, misaligned-load detection and an optional retired-instruction counter.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold MEM/WB register, suppress commit
- flush  in  1  hazard unit: invalidate MEM/WB register at next edge; overrides stall
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_reg_write  in  1  instruction writes rd
- mem_rd  in  5  destination register
- mem_wb_sel  in  2  00 ALU result, 01 load, 10 PC+4, 11 immediate (LUI)
- mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- mem_alu_result  in  32  ALU result; bits [1:0] are the load byte offset
- mem_pc_plus4  in  32  link value
- mem_imm  in  32  U-type immediate
- mem_load_word  in  32  registered word from the memory stage, valid in the cycle after capture (same cycle the instruction is in WB)
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- fwd_valid  out  1  forwarding bus valid (equals rf_we)
- load_misaligned  out  1  one-cycle pulse on misaligned load commit
- retire  out  1  one-cycle pulse per committed instruction
- instret  out  64  retired count (only with WB_INSTRET_EN)

## Operation
- MEM/WB register fields: valid, reg_write, rd, wb_sel, funct3, alu_result, pc_plus4, imm.
- Each edge: flush -> valid=0, other fields unchanged; else stall -> hold all; else capture all mem_* fields.
- Load extraction from mem_load_word using offset = alu_result[1:0]: byte = word[8*offset+:8], half = word[16*offset[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word. Undefined funct3 yields the whole word.
- Misaligned: LW with offset≠0; LH/LHU with offset[0]=1. Applies only when wb_sel=01.
- rf_wdata = mux(wb_sel) over ALU / extracted load / pc_plus4 / imm; forced 0 when valid=0.
- commit = valid & !stall.
- rf_we = commit & reg_write & (rd≠0) & !misaligned; rf_waddr = rd.
- retire = commit & !misaligned; load_misaligned = commit & misaligned.
- The x0 write is suppressed but still retires.

## Timing
- Reset (async): valid=0, all fields 0; rf_we=0, rf_waddr=0, rf_wdata=0, fwd_valid=0, retire=0, load_misaligned=0, instret=0.
- Latency: instruction accepted at edge N commits (rf_we) in cycle N→N+1; rf_wdata is combinational from the register plus mem_load_word.
- The register file writes at edge N+1.
- Stall held for k cycles: a single commit, in the first cycle stall=0; no double retire.
- flush with stall both high: flush wins, and the instruction never commits.
- Reset mid-stall clears the pending instruction with no commit.
- Back-to-back valid instructions commit one per cycle with no bubble.

## Configuration
- WB_INSTRET_EN defined: 64-bit instret register, increments by 1 on retire, wraps 2^64−1 → 0, reset 0.
- WB_INSTRET_EN undefined: the instret port and counter are absent; all other behaviour is identical.

## Test plan
- LB, offset 3, word 0x80FF_1234: rd=5 → rf_we=1, rf_waddr=5, rf_wdata=0xFFFF_FF80. The same instruction as LBU → 0x0000_0080.
- LH, offset 2, word 0x8001_7FFF → 0xFFFF_8001. LW, offset 1 → rf_we=0, load_misaligned=1, retire=0.
- JAL, wb_sel=10, pc_plus4=0x0000_0104, rd=1 → rf_wdata=0x104. The same with rd=0 → rf_we=0, retire=1.
- Valid ALU op (0x1234, rd=7) captured, stall high 3 cycles, then low → exactly one rf_we and one retire, in the cycle after stall drops.
- Capture instruction, assert flush and stall together → no rf_we and no retire. Assert n_rst mid-stream → all outputs 0 immediately.
- WB_INSTRET_EN: preload-free run of 10 committed instructions, 1 misaligned, 2 flushed → instret=10.
